// File: rtl/axis_slave_frame_checker.sv
// AXI4-Stream sink for the ADC sample stream: buffers {tlast,tdata} in a FWFT FIFO
// and checks sample continuity and frame boundaries, reporting error pulses and counters.
module axis_slave_frame_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axis_tstrb,
    input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          seq_error,
    output logic                          tlast_error,
    output logic [CNT_WIDTH-1:0]          frame_count,
    output logic [CNT_WIDTH-1:0]          err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Byte qualifiers carry no information for this stream; fold them away explicitly.
    logic unused_sideband;
    assign unused_sideband = ^{s_axis_tstrb, s_axis_tkeep};

    // Released one edge after aresetn rises, so tready never rises asynchronously.
    logic ready_en;
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) ready_en <= 1'b0;
        else                 ready_en <= 1'b1;
    end

    entry_t          mem [FIFO_DEPTH];
    entry_t          last_pop_q;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            accept;
    logic            pop;

    assign full          = (count == (AW+1)'(FIFO_DEPTH));
    assign s_axis_tready = ready_en & ~full;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign rd_valid      = (count != '0);
    assign pop           = rd_en & rd_valid;
    assign fifo_count    = count;

    // When empty the head shows the last popped entry, which is zero straight after reset.
    assign head    = rd_valid ? mem[rd_ptr] : last_pop_q;
    assign rd_data = head.data;
    assign rd_last = head.last;

    // NOTE: the storage array has no reset; an entry is only ever observed after it was written.
    always_ff @(posedge s_axis_aclk) begin
        if (accept) mem[wr_ptr] <= '{last: s_axis_tlast, data: s_axis_tdata};
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_pop_q <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                last_pop_q <= mem[rd_ptr];
            end
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    logic                  seeded;
    logic [DATA_WIDTH-1:0] expected;
    logic [IW-1:0]         idx;
    logic                  seq_err_n;
    logic                  tl_err_n;
    logic                  at_last;
    logic [CNT_WIDTH:0]    err_sum;
    logic [CNT_WIDTH-1:0]  err_next;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        at_last   = (idx == LAST_IDX);
        seq_err_n = 1'b0;
        tl_err_n  = 1'b0;
        if (accept) begin
            seq_err_n = seeded && (s_axis_tdata != expected);
            tl_err_n  = (s_axis_tlast != at_last);
        end
        err_sum  = {1'b0, err_count} + (CNT_WIDTH+1)'(seq_err_n) + (CNT_WIDTH+1)'(tl_err_n);
        err_next = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            seeded      <= 1'b0;
            expected    <= '0;
            idx         <= '0;
            seq_error   <= 1'b0;
            tlast_error <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            seq_error   <= seq_err_n;
            tlast_error <= tl_err_n;
            err_count   <= err_next;
            if (accept) begin
                seeded   <= 1'b1;
                expected <= s_axis_tdata + DATA_WIDTH'(1);
                // Any tlast or the final index closes the frame, correct or not.
                idx <= (s_axis_tlast || at_last) ? '0 : idx + IW'(1);
                if (s_axis_tlast) frame_count <= frame_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_slave_frame_checker.sv
// Directed bench for axis_slave_frame_checker: scoreboarded FIFO output plus
// hand-computed continuity/framing error expectations and a random-handshake soak.
module tb_axis_slave_frame_checker;

    logic        s_axis_aclk = 1'b0;
    logic        s_axis_aresetn = 1'b1;
    logic [15:0] s_axis_tdata = '0;
    logic [1:0]  s_axis_tstrb = '1;
    logic [1:0]  s_axis_tkeep = '1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_last;
    logic [4:0]  fifo_count;
    logic        seq_error;
    logic        tlast_error;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    always #5 s_axis_aclk = ~s_axis_aclk;

    axis_slave_frame_checker dut (
        .s_axis_aclk   (s_axis_aclk),
        .s_axis_aresetn(s_axis_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .rd_en         (rd_en),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .fifo_count    (fifo_count),
        .seq_error     (seq_error),
        .tlast_error   (tlast_error),
        .frame_count   (frame_count),
        .err_count     (err_count)
    );

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t       q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          bidx = 0;
    logic [15:0] next_data = '0;
    bit          rdy_m = 1'b0;
    bit          soak = 1'b0;
    int          seq_seen = 0;
    int          tl_seen = 0;
    int          last_pops = 0;
    logic        last_seq;
    logic        last_tl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the FIFO head and handshake before the edge, update the model after it.
    task automatic tick(output bit acc);
        bit    pop;
        beat_t head;
        beat_t inb;
        acc = s_axis_tvalid && rdy_m && (q.size() < 16);
        check("tready", s_axis_tready, rdy_m && (q.size() < 16));
        check("rd_valid", rd_valid, q.size() != 0);
        pop = rd_en && (q.size() != 0);
        if (pop) begin
            head = q[0];
            check("rd_data", rd_data, head.d);
            check("rd_last", rd_last, head.l);
        end
        inb.d = s_axis_tdata;
        inb.l = s_axis_tlast;
        @(posedge s_axis_aclk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            if (head.l) last_pops++;
        end
        if (acc) q.push_back(inb);
        if (s_axis_aresetn) rdy_m = 1'b1;
        seq_seen += int'(seq_error);
        tl_seen  += int'(tlast_error);
        check("fifo_count", fifo_count, q.size());
        if (soak) rd_en = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        bit a;
        s_axis_tvalid = 1'b0;
        repeat (n) tick(a);
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l);
        bit acc;
        acc = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        for (int n = 0; n < 64 && !acc; n++) tick(acc);
        check("beat_accepted", acc, 1);
        last_seq = seq_error;
        last_tl  = tlast_error;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) begin
            if (soak) idle($urandom_range(0, 2));
            send_beat(next_data, bidx == 63);
            next_data++;
            bidx = (bidx == 63) ? 0 : bidx + 1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tready"}, s_axis_tready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_seq_error"}, seq_error, 0);
        check({tag, "_tlast_error"}, tlast_error, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    task automatic do_reset(input string tag);
        s_axis_aresetn = 1'b0;
        #1;
        check_zero(tag);
        q.delete();
        rdy_m = 1'b0;
        bidx = 0;
        seq_seen = 0;
        tl_seen = 0;
        last_pops = 0;
        repeat (2) @(posedge s_axis_aclk);
        @(negedge s_axis_aclk);
        s_axis_aresetn = 1'b1;
        #1;
        check({tag, "_tready_at_release"}, s_axis_tready, 0);
        idle(1);
        check({tag, "_tready_after_edge"}, s_axis_tready, 1);
    endtask

    initial begin
        bit acc;
        @(posedge s_axis_aclk);
        #1;

        // T1: two clean frames, consumer always ready
        do_reset("reset");
        rd_en = 1'b1;
        next_data = 16'd0;
        send_clean(128);
        idle(4);
        check("t1_frame_count", frame_count, 2);
        check("t1_err_count", err_count, 0);
        check("t1_last_pops", last_pops, 2);
        check("t1_hold_rd_data", rd_data, 16'd127);
        check("t1_hold_rd_last", rd_last, 1);

        // T2: backpressure at 16 entries, one pop re-opens tready
        rd_en = 1'b0;
        send_clean(16);
        check("t2_full_count", fifo_count, 16);
        check("t2_tready_low", s_axis_tready, 0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = next_data;
        s_axis_tlast  = 1'b0;
        repeat (3) tick(acc);
        check("t2_still_full", fifo_count, 16);
        rd_en = 1'b1;
        tick(acc);
        rd_en = 1'b0;
        check("t2_tready_after_pop", s_axis_tready, 1);
        check("t2_count_after_pop", fifo_count, 15);
        send_clean(1);
        check("t2_beat17_count", fifo_count, 16);
        rd_en = 1'b1;
        send_clean(47);
        idle(20);
        check("t2_frame_count", frame_count, 3);
        check("t2_err_count", err_count, 0);

        // T3: continuity break 5,6,8,9
        do_reset("t3_reset");
        rd_en = 1'b1;
        send_beat(16'd5, 1'b0);
        check("t3_seed_no_err", last_seq, 0);
        send_beat(16'd6, 1'b0);
        check("t3_b6", last_seq, 0);
        send_beat(16'd8, 1'b0);
        check("t3_b8_pulse", last_seq, 1);
        send_beat(16'd9, 1'b0);
        check("t3_b9_resync", last_seq, 0);
        check("t3_err_count", err_count, 1);
        bidx = 4;
        next_data = 16'd10;
        send_clean(60);
        idle(3);
        check("t3_err_count_end", err_count, 1);
        check("t3_seq_pulses", seq_seen, 1);
        check("t3_frame_count", frame_count, 1);
        check("t3_no_tlast_err", tl_seen, 0);

        // T4: early tlast at index 10, then a missing tlast at index 63
        do_reset("t4_reset");
        next_data = 16'd0;
        send_clean(10);
        send_beat(16'd10, 1'b1);
        check("t4_early_tlast", last_tl, 1);
        check("t4_early_seq", last_seq, 0);
        idle(1);
        check("t4_err_count", err_count, 1);
        check("t4_frame_count", frame_count, 1);
        bidx = 0;
        next_data = 16'd11;
        send_clean(64);
        idle(2);
        check("t4_clean_err", err_count, 1);
        check("t4_clean_frames", frame_count, 2);
        check("t4_tl_pulses", tl_seen, 1);
        send_clean(63);
        send_beat(next_data, 1'b0);
        check("t4_missing_tlast", last_tl, 1);
        next_data++;
        bidx = 0;
        send_clean(64);
        idle(3);
        check("t4_err_count_end", err_count, 2);
        check("t4_frame_count_end", frame_count, 3);

        // T5: wrap through 0xFFFF is legal; a combined error counts twice
        do_reset("t5_reset");
        send_beat(16'hFFFE, 1'b0);
        send_beat(16'hFFFF, 1'b0);
        check("t5_ffff", last_seq, 0);
        send_beat(16'h0000, 1'b0);
        check("t5_wrap", last_seq, 0);
        send_beat(16'h0001, 1'b0);
        check("t5_after_wrap", last_seq, 0);
        check("t5_err_count", err_count, 0);
        send_beat(16'h0007, 1'b1);
        check("t5_both_seq", last_seq, 1);
        check("t5_both_tlast", last_tl, 1);
        check("t5_err_count_two", err_count, 2);
        idle(3);

        // T6: reset mid-frame with five entries buffered
        do_reset("t6_reset");
        next_data = 16'd0;
        send_clean(25);
        idle(3);
        rd_en = 1'b0;
        send_clean(5);
        check("t6_count_before", fifo_count, 5);
        do_reset("t6_midframe");
        rd_en = 1'b1;
        next_data = 16'd100;
        send_clean(64);
        idle(3);
        check("t6_err_count", err_count, 0);
        check("t6_frame_count", frame_count, 1);
        check("t6_last_pops", last_pops, 1);

        // Soak: random tvalid gaps and random consumer pops over ten frames
        soak = 1'b1;
        send_clean(640);
        soak = 1'b0;
        rd_en = 1'b1;
        idle(24);
        check("soak_err_count", err_count, 0);
        check("soak_frame_count", frame_count, 11);
        check("soak_drained", fifo_count, 0);
        check("soak_scoreboard_empty", q.size(), 0);
        check("soak_last_pops", last_pops, 11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
